// File: rtl/st_irq_ctrl.sv
// Atari ST interrupt priority controller: encodes MFP/VBL/HBL onto the 68000 IPL lines
// and answers IACK cycles with an MFP vector, an autovector (VPA) or the spurious vector.
module st_irq_ctrl #(
  parameter int unsigned MFP_IACK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hbl,
  input  logic       vbl,
  input  logic       mfp_irq,
  input  logic [7:0] mfp_dout,
  input  logic       cpu_as_n,
  input  logic [2:0] cpu_fc,
  input  logic [2:0] cpu_addr,
  output logic [2:0] cpu_ipl_n,
  output logic       cpu_vpa_n,
  output logic       cpu_dtack_n,
  output logic [7:0] vec_out,
  output logic       vec_oe,
  output logic       mfp_iack
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_MFP_WAIT = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(MFP_IACK_CYCLES);
  localparam logic [7:0] SPURIOUS_VEC = 8'h18;

  logic [1:0] state_q, state_d;
  logic [2:0] ack_lvl_q, ack_lvl_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hbl_dly_q, hbl_dly_d;
  logic       vbl_dly_q, vbl_dly_d;
  logic       hbl_pend_q, hbl_pend_d;
  logic       vbl_pend_q, vbl_pend_d;
  logic [2:0] ipl_q, ipl_d;
  logic       vpa_q, vpa_d;
  logic       dtack_q, dtack_d;
  logic [7:0] vec_q, vec_d;
  logic       oe_q, oe_d;
  logic       iack_q, iack_d;

  logic [2:0] lvl;
  logic       iack_start;
  logic       clr_hbl, clr_vbl;
  logic       release_hs;

  always_comb begin
    if (mfp_irq)         lvl = 3'd6;
    else if (vbl_pend_q) lvl = 3'd4;
    else if (hbl_pend_q) lvl = 3'd2;
    else                 lvl = 3'd0;
  end

  assign iack_start = (cpu_fc == 3'b111) && !cpu_as_n;

  always_comb begin
    state_d    = state_q;
    ack_lvl_d  = ack_lvl_q;
    cnt_d      = cnt_q;
    vpa_d      = vpa_q;
    dtack_d    = dtack_q;
    vec_d      = vec_q;
    oe_d       = oe_q;
    iack_d     = iack_q;
    clr_hbl    = 1'b0;
    clr_vbl    = 1'b0;
    release_hs = 1'b0;
    hbl_dly_d  = hbl;
    vbl_dly_d  = vbl;
    ipl_d      = ~lvl;

    case (state_q)
      S_IDLE: begin
        if (iack_start) begin
          ack_lvl_d = cpu_addr;
          state_d   = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (cpu_as_n) begin
          release_hs = 1'b1;
        end else if (ack_lvl_q == 3'd6 && mfp_irq) begin
          iack_d  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = S_MFP_WAIT;
        end else if (ack_lvl_q == 3'd4 && vbl_pend_q) begin
          vpa_d   = 1'b0;
          clr_vbl = 1'b1;
          state_d = S_DONE;
        end else if (ack_lvl_q == 3'd2 && hbl_pend_q) begin
          vpa_d   = 1'b0;
          clr_hbl = 1'b1;
          state_d = S_DONE;
        end else begin
          vec_d   = SPURIOUS_VEC;
          oe_d    = 1'b1;
          dtack_d = 1'b0;
          state_d = S_DONE;
        end
      end
      S_MFP_WAIT: begin
        if (cpu_as_n) begin
          release_hs = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            vec_d   = mfp_dout;
            oe_d    = 1'b1;
            dtack_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (cpu_as_n) release_hs = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Release and abort share one path; vec_out intentionally keeps its last value.
    if (release_hs) begin
      iack_d  = 1'b0;
      vpa_d   = 1'b1;
      dtack_d = 1'b1;
      oe_d    = 1'b0;
      state_d = S_IDLE;
    end

    // A new strobe edge in the same cycle as an autovector clear keeps the flag set.
    hbl_pend_d = (hbl_pend_q && !clr_hbl) || (hbl && !hbl_dly_q);
    vbl_pend_d = (vbl_pend_q && !clr_vbl) || (vbl && !vbl_dly_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ack_lvl_q  <= '0;
      cnt_q      <= '0;
      hbl_dly_q  <= 1'b0;
      vbl_dly_q  <= 1'b0;
      hbl_pend_q <= 1'b0;
      vbl_pend_q <= 1'b0;
      ipl_q      <= '1;
      vpa_q      <= 1'b1;
      dtack_q    <= 1'b1;
      vec_q      <= '0;
      oe_q       <= 1'b0;
      iack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_lvl_q  <= ack_lvl_d;
      cnt_q      <= cnt_d;
      hbl_dly_q  <= hbl_dly_d;
      vbl_dly_q  <= vbl_dly_d;
      hbl_pend_q <= hbl_pend_d;
      vbl_pend_q <= vbl_pend_d;
      ipl_q      <= ipl_d;
      vpa_q      <= vpa_d;
      dtack_q    <= dtack_d;
      vec_q      <= vec_d;
      oe_q       <= oe_d;
      iack_q     <= iack_d;
    end
  end

  assign cpu_ipl_n   = ipl_q;
  assign cpu_vpa_n   = vpa_q;
  assign cpu_dtack_n = dtack_q;
  assign vec_out     = vec_q;
  assign vec_oe      = oe_q;
  assign mfp_iack    = iack_q;

endmodule
